// File: rtl/fm_ram_write_arbiter_pkg.sv
// Shared definitions for the feature-map RAM write arbiter: default geometry,
// watchdog limit and the 3-bit FSM state encoding.
package fm_ram_write_arbiter_pkg;

  localparam int DATA_WIDTH_DEF       = 16;
  localparam int PARA_Y_DEF           = 3;
  localparam int PARA_KERNEL_DEF      = 3;
  localparam int WRITE_ADDR_WIDTH_DEF = 12;
  localparam int TIMEOUT_CYCLES_DEF   = 64;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ZERO    = 3'd1;
  localparam logic [2:0] ST_PARA    = 3'd2;
  localparam logic [2:0] ST_WORD    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ZERO    = ST_ZERO,
    S_PARA    = ST_PARA,
    S_WORD    = ST_WORD,
    S_RELEASE = ST_RELEASE
  } wr_state_t;

endpackage

// File: rtl/fm_ram_write_arbiter_rr.sv
// fm_rr_arbiter_2: two-way round-robin grant. Grants are combinational; the
// pointer flips to the other port whenever a grant is taken.
module fm_rr_arbiter_2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  logic r_ptr_b;

  always_comb begin
    o_grant_a = 1'b0;
    o_grant_b = 1'b0;
    if (i_en) begin
      if (i_req_a && (!i_req_b || !r_ptr_b)) begin
        o_grant_a = 1'b1;
      end else if (i_req_b) begin
        o_grant_b = 1'b1;
      end
    end
  end

  // A grant only exists when its request is high, so a grant is an accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr_b <= 1'b0;
    end else if (o_grant_a) begin
      r_ptr_b <= 1'b1;
    end else if (o_grant_b) begin
      r_ptr_b <= 1'b0;
    end
  end

endmodule

// File: rtl/fm_ram_write_arbiter.sv
// Write-side controller for the float16 feature-map RAM: arbitrates para/word
// writers, owns ram_swap and the zero-clear. Option: FM_WRITE_TIMEOUT_EN.
module fm_ram_write_arbiter
  import fm_ram_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int PARA_Y           = PARA_Y_DEF,
  parameter int PARA_KERNEL      = PARA_KERNEL_DEF,
  parameter int WRITE_ADDR_WIDTH = WRITE_ADDR_WIDTH_DEF
`ifdef FM_WRITE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_zero_req,
  input  logic                                      i_layer_done,
  input  logic                                      i_a_valid,
  output logic                                      o_a_ready,
  input  logic                                      i_a_add,
  input  logic [WRITE_ADDR_WIDTH-1:0]               i_a_addr,
  input  logic [PARA_Y*PARA_KERNEL*DATA_WIDTH-1:0]  i_a_data,
  input  logic                                      i_b_valid,
  output logic                                      o_b_ready,
  input  logic                                      i_b_add,
  input  logic [WRITE_ADDR_WIDTH-1:0]               i_b_addr,
  input  logic [PARA_Y*DATA_WIDTH-1:0]              i_b_data,
  input  logic                                      i_write_ready,
  output logic                                      o_ena_zero_w,
  output logic                                      o_ram_swap,
  output logic                                      o_ena_w,
  output logic                                      o_ena_para_w,
  output logic                                      o_ena_add_write,
  output logic [WRITE_ADDR_WIDTH-1:0]               o_addr_write,
  output logic [PARA_Y*DATA_WIDTH-1:0]              o_din,
  output logic [WRITE_ADDR_WIDTH-1:0]               o_addr_para_write,
  output logic [PARA_Y*PARA_KERNEL*DATA_WIDTH-1:0]  o_para_din,
`ifdef FM_WRITE_TIMEOUT_EN
  output logic                                      o_timeout_err,
`endif
  output logic                                      o_busy
);

  wr_state_t                                r_state;
  logic                                     r_swap_pend, r_zero_pend, r_ram_swap;
  logic                                     r_ena_zero_w, r_ena_w, r_ena_para_w, r_ena_add;
  logic [WRITE_ADDR_WIDTH-1:0]              r_addr_write, r_addr_para_write;
  logic [PARA_Y*DATA_WIDTH-1:0]             r_din;
  logic [PARA_Y*PARA_KERNEL*DATA_WIDTH-1:0] r_para_din;
  logic                                     w_arb_en, w_grant_a, w_grant_b;

`ifdef FM_WRITE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;
  assign o_timeout_err = r_timeout_err;
`endif

  // Pending housekeeping blocks new grants so swap/clear are never starved.
  assign w_arb_en = (r_state == S_IDLE) && !r_swap_pend && !r_zero_pend;

  fm_rr_arbiter_2 u_rr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (w_arb_en),
    .i_req_a   (i_a_valid),
    .i_req_b   (i_b_valid),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= S_IDLE;
      r_swap_pend       <= 1'b0;
      r_zero_pend       <= 1'b0;
      r_ram_swap        <= 1'b0;
      r_ena_zero_w      <= 1'b0;
      r_ena_w           <= 1'b0;
      r_ena_para_w      <= 1'b0;
      r_ena_add         <= 1'b0;
      r_addr_write      <= '0;
      r_addr_para_write <= '0;
      r_din             <= '0;
      r_para_din        <= '0;
`ifdef FM_WRITE_TIMEOUT_EN
      r_wait_cnt        <= '0;
      r_timeout_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_swap_pend) begin
            r_ram_swap  <= ~r_ram_swap;
            r_swap_pend <= 1'b0;
          end else if (r_zero_pend) begin
            r_zero_pend  <= 1'b0;
            r_ena_zero_w <= 1'b1;
            r_state      <= S_ZERO;
          end else if (w_grant_a) begin
            r_addr_para_write <= i_a_addr;
            r_para_din        <= i_a_data;
            r_ena_add         <= i_a_add;
            r_ena_para_w      <= 1'b1;
            r_state           <= S_PARA;
`ifdef FM_WRITE_TIMEOUT_EN
            r_wait_cnt        <= '0;
`endif
          end else if (w_grant_b) begin
            r_addr_write <= i_b_addr;
            r_din        <= i_b_data;
            r_ena_add    <= i_b_add;
            r_ena_w      <= 1'b1;
            r_state      <= S_WORD;
`ifdef FM_WRITE_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
          end
        end
        S_ZERO: begin
          r_ena_zero_w <= 1'b0;
          r_state      <= S_IDLE;
        end
        S_PARA, S_WORD: begin
          // Overwriting word writes complete in one cycle; all others wait.
          if ((r_state == S_WORD && !r_ena_add) || i_write_ready) begin
            r_ena_w      <= 1'b0;
            r_ena_para_w <= 1'b0;
            r_ena_add    <= 1'b0;
            r_state      <= r_ena_add || (r_state == S_PARA) ? S_RELEASE : S_IDLE;
`ifdef FM_WRITE_TIMEOUT_EN
          end else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_ena_w       <= 1'b0;
            r_ena_para_w  <= 1'b0;
            r_ena_add     <= 1'b0;
            r_state       <= S_RELEASE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed after the service above so a pulse in the service cycle survives.
      if (i_layer_done) r_swap_pend <= 1'b1;
      if (i_zero_req)   r_zero_pend <= 1'b1;
    end
  end

  assign o_a_ready         = w_grant_a;
  assign o_b_ready         = w_grant_b;
  assign o_ena_zero_w      = r_ena_zero_w;
  assign o_ram_swap        = r_ram_swap;
  assign o_ena_w           = r_ena_w;
  assign o_ena_para_w      = r_ena_para_w;
  assign o_ena_add_write   = r_ena_add;
  assign o_addr_write      = r_addr_write;
  assign o_din             = r_din;
  assign o_addr_para_write = r_addr_para_write;
  assign o_para_din        = r_para_din;
  assign o_busy            = (r_state != S_IDLE) || r_swap_pend || r_zero_pend;

endmodule

// File: tb/tb_fm_ram_write_arbiter.sv
// Directed bench for fm_ram_write_arbiter: vector table of single transactions
// plus hand sequences for arbitration, swap/clear ordering, reset and timeout.
module tb_fm_ram_write_arbiter;

  localparam int DW = 16;
  localparam int PY = 3;
  localparam int PK = 3;
  localparam int AW = 12;

  logic                  clk = 1'b0;
  logic                  rst, zero_req, layer_done;
  logic                  a_valid, a_add, b_valid, b_add;
  logic [AW-1:0]         a_addr, b_addr;
  logic [PY*PK*DW-1:0]   a_data;
  logic [PY*DW-1:0]      b_data;
  logic                  write_ready;
  logic                  a_ready, b_ready, ena_zero_w, ram_swap, ena_w, ena_para_w;
  logic                  ena_add_write, busy;
  logic [AW-1:0]         addr_write, addr_para_write;
  logic [PY*DW-1:0]      din;
  logic [PY*PK*DW-1:0]   para_din;
`ifdef FM_WRITE_TIMEOUT_EN
  logic                  timeout_err;
`endif

  fm_ram_write_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_zero_req(zero_req), .i_layer_done(layer_done),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_add(a_add), .i_a_addr(a_addr),
    .i_a_data(a_data), .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_add(b_add),
    .i_b_addr(b_addr), .i_b_data(b_data), .i_write_ready(write_ready),
    .o_ena_zero_w(ena_zero_w), .o_ram_swap(ram_swap), .o_ena_w(ena_w),
    .o_ena_para_w(ena_para_w), .o_ena_add_write(ena_add_write),
    .o_addr_write(addr_write), .o_din(din), .o_addr_para_write(addr_para_write),
    .o_para_din(para_din),
`ifdef FM_WRITE_TIMEOUT_EN
    .o_timeout_err(timeout_err),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: raises write_ready in the last cycle of its latency window.
  logic       model_en, wr_force;
  logic [7:0] m_cnt, m_lat;
  wire        m_wait = ena_para_w | (ena_w & ena_add_write);
  always_comb m_lat = ena_para_w ? (ena_add_write ? 8'(2 * PK) : 8'(PK)) : 8'd2;
  always @(posedge clk) begin
    if (rst || !m_wait) m_cnt <= 8'd0;
    else                m_cnt <= m_cnt + 8'd1;
  end
  assign write_ready = wr_force | (model_en & m_wait & (m_cnt == m_lat - 8'd1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PY*PK*DW-1:0] a_pat(input logic [AW-1:0] ad);
    return {9{4'hA, ad}};
  endfunction

  function automatic logic [PY*DW-1:0] b_pat(input logic [AW-1:0] ad);
    return {3{4'hB, ad}};
  endfunction

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && busy; i++) step();
    chk({nm, ".idle"}, busy, 1'b0);
  endtask

  typedef struct {
    logic          av;
    logic          aadd;
    logic [AW-1:0] aaddr;
    logic          bv;
    logic          badd;
    logic [AW-1:0] baddr;
    logic          exp_ar;
    logic          exp_br;
    int            exp_para;
    int            exp_word;
    int            exp_rel;
    logic          exp_add;
  } vec_t;

  // Drive one request from IDLE, then measure the enable pattern until idle.
  task automatic run_txn(input vec_t v, input string tag);
    int para, word, rel, ovl, bad;
    logic add_seen;
    a_valid = v.av; a_add = v.aadd; a_addr = v.aaddr; a_data = a_pat(v.aaddr);
    b_valid = v.bv; b_add = v.badd; b_addr = v.baddr; b_data = b_pat(v.baddr);
    #1;
    chk({tag, ".a_ready"}, a_ready, v.exp_ar);
    chk({tag, ".b_ready"}, b_ready, v.exp_br);
    step();
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    para = 0; word = 0; rel = 0; ovl = 0; bad = 0; add_seen = 1'b0;
    for (int c = 0; c < 200 && busy; c++) begin
      if (ena_para_w) begin
        para++;
        add_seen = ena_add_write;
        if (addr_para_write !== v.aaddr || para_din !== a_pat(v.aaddr)) bad++;
      end
      if (ena_w) begin
        word++;
        add_seen = ena_add_write;
        if (addr_write !== v.baddr || din !== b_pat(v.baddr)) bad++;
      end
      if (int'(ena_para_w) + int'(ena_w) + int'(ena_zero_w) > 1) ovl++;
      if (!ena_para_w && !ena_w && !ena_zero_w) rel++;
      step();
    end
    chk({tag, ".idle"}, busy, 1'b0);
    chk({tag, ".para_cycles"}, para, v.exp_para);
    chk({tag, ".word_cycles"}, word, v.exp_word);
    chk({tag, ".release_cycles"}, rel, v.exp_rel);
    chk({tag, ".add_write"}, add_seen, v.exp_add);
    chk({tag, ".addr_data_errs"}, bad, 0);
    chk({tag, ".overlap"}, ovl, 0);
    $display("txn %s: para=%0d word=%0d release=%0d add=%0b", tag, para, word, rel, add_seen);
  endtask

  vec_t vecs[7];

  initial begin
    int   g, para, zeros, swap_at, zero_at, ovl;
    byte  seq[6];
    logic swap_in_zero, busy9;
    vec_t v;

    vecs[0] = '{1'b1, 1'b1, 12'd5,  1'b0, 1'b0, 12'd0,  1'b1, 1'b0, 6, 0, 1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 12'd0,  1'b1, 1'b0, 12'd3,  1'b0, 1'b1, 0, 1, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 12'd7,  1'b1, 1'b1, 12'd9,  1'b1, 1'b0, 3, 0, 1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 12'd8,  1'b1, 1'b1, 12'd10, 1'b0, 1'b1, 0, 2, 1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 12'd0,  1'b1, 1'b1, 12'd11, 1'b0, 1'b1, 0, 2, 1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 12'd12, 1'b0, 1'b0, 12'd0,  1'b1, 1'b0, 3, 0, 1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 12'd14, 1'b1, 1'b0, 12'd13, 1'b0, 1'b1, 0, 1, 0, 1'b0};

    rst = 1'b1; zero_req = 1'b0; layer_done = 1'b0;
    a_valid = 1'b0; a_add = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_add = 1'b0; b_addr = '0; b_data = '0;
    model_en = 1'b1; wr_force = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset.enables", {ena_zero_w, ena_w, ena_para_w, ena_add_write}, 4'b0);
    chk("reset.ram_swap", ram_swap, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.addr_din", {addr_write, din, addr_para_write}, '0);
`ifdef FM_WRITE_TIMEOUT_EN
    chk("reset.timeout_err", timeout_err, 1'b0);
`endif
    $display("reset: busy=%0b ram_swap=%0b", busy, ram_swap);

    // write_ready while idle must not start anything.
    wr_force = 1'b1;
    repeat (3) step();
    chk("idle_wr.busy", busy, 1'b0);
    chk("idle_wr.enables", {ena_zero_w, ena_w, ena_para_w}, 3'b0);
    wr_force = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held: grants must alternate starting with A.
    a_valid = 1'b1; a_add = 1'b0; a_addr = 12'd20; a_data = a_pat(12'd20);
    b_valid = 1'b1; b_add = 1'b0; b_addr = 12'd21; b_data = b_pat(12'd21);
    g = 0; ovl = 0;
    for (int c = 0; c < 300 && g < 6; c++) begin
      #1;
      if (a_ready && b_ready) ovl++;
      if (int'(ena_para_w) + int'(ena_w) + int'(ena_zero_w) > 1) ovl++;
      if (a_ready) begin seq[g] = "A"; g++; end
      else if (b_ready) begin seq[g] = "B"; g++; end
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("alt.grants", g, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("alt.grant%0d", i), seq[i], (i % 2 == 0) ? 8'h41 : 8'h42);
    chk("alt.overlap", ovl, 0);
    wait_idle("alt");
    $display("alternation: %0d grants", g);

    // Swap and clear pulsed together during a para write.
    a_valid = 1'b1; a_add = 1'b1; a_addr = 12'd30; a_data = a_pat(12'd30);
    #1;
    chk("swz.a_ready", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
    para = 0; zeros = 0; swap_at = -1; zero_at = -1; swap_in_zero = 1'b0; busy9 = 1'b0;
    for (int rel = 1; rel <= 14; rel++) begin
      if (ena_para_w) para++;
      if (ram_swap && swap_at < 0) swap_at = rel;
      if (ena_zero_w) begin
        zeros++;
        if (zero_at < 0) zero_at = rel;
        swap_in_zero = ram_swap;
      end
      if (rel == 9) busy9 = busy;
      layer_done = (rel == 2);
      zero_req   = (rel == 2) || (rel == 3);
      step();
    end
    layer_done = 1'b0; zero_req = 1'b0;
    chk("swz.para_cycles", para, 6);
    chk("swz.swap_at", swap_at, 9);
    chk("swz.zero_at", zero_at, 10);
    chk("swz.zero_count", zeros, 1);
    chk("swz.swap_before_zero", swap_in_zero, 1'b1);
    chk("swz.busy_rel9", busy9, 1'b1);
    chk("swz.busy_end", busy, 1'b0);
    $display("swap/zero: swap_at=%0d zero_at=%0d zeros=%0d", swap_at, zero_at, zeros);

    // Reset in the middle of a para write.
    a_valid = 1'b1; a_add = 1'b1; a_addr = 12'd40; a_data = a_pat(12'd40);
    step();
    a_valid = 1'b0;
    step();
    chk("rst_mid.in_para", ena_para_w, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid.enables", {ena_zero_w, ena_w, ena_para_w, ena_add_write}, 4'b0);
    chk("rst_mid.ram_swap", ram_swap, 1'b0);
    chk("rst_mid.busy", busy, 1'b0);
    $display("reset mid-para: busy=%0b ram_swap=%0b", busy, ram_swap);
    v = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 12'd41, 1'b0, 1'b1, 0, 1, 0, 1'b0};
    run_txn(v, "post_rst");

`ifdef FM_WRITE_TIMEOUT_EN
    model_en = 1'b0;
    v = '{1'b1, 1'b1, 12'd50, 1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 64, 0, 1, 1'b1};
    run_txn(v, "timeout");
    chk("timeout.err", timeout_err, 1'b1);
    repeat (3) step();
    chk("timeout.sticky", timeout_err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("timeout.cleared", timeout_err, 1'b0);
    model_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fm_ram_write_arbiter.md
Name: fm_ram_write_arbiter

Overview:
Write-side controller for the float16 feature-map RAM. Arbitrates between two requesters and sequences the RAM's enable/write_ready protocol:
- Port A: conv/fc result unit, issues PARA_KERNEL-wide para writes.
- Port B: pool/single-vector unit, issues PARA_Y-wide writes.

Also owns the ping-pong half select (ram_swap) and the zero-clear of the write half at layer boundaries. Sits between the layer sequencer, the MAC/pool result paths and the RAM.

Parameters:
DATA_WIDTH, 16, float16 element width
PARA_Y, 3, elements per RAM word
PARA_KERNEL, 3, kernels per para write
WRITE_ADDR_WIDTH, 12, RAM write address width
TIMEOUT_CYCLES, 64, watchdog limit (optional feature only)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
zero_req  in  1  pulse: clear current write half
layer_done  in  1  pulse: toggle ram_swap
a_valid  in  1  port A request
a_ready  out  1  port A accept (combinational)
a_add  in  1  1 = accumulate, 0 = overwrite
a_addr  in  WRITE_ADDR_WIDTH  para write address
a_data  in  PARA_Y*PARA_KERNEL*DATA_WIDTH  para data
b_valid  in  1  port B request
b_ready  out  1  port B accept (combinational)
b_add  in  1  1 = accumulate, 0 = overwrite
b_addr  in  WRITE_ADDR_WIDTH  word write address
b_data  in  PARA_Y*DATA_WIDTH  word data
write_ready  in  1  RAM completion flag
ena_zero_w  out  1  RAM zero-clear enable
ram_swap  out  1  RAM half select
ena_w  out  1  RAM word-write enable
ena_para_w  out  1  RAM para-write enable
ena_add_write  out  1  RAM accumulate select
addr_write  out  WRITE_ADDR_WIDTH  to RAM
din  out  PARA_Y*DATA_WIDTH  to RAM
addr_para_write  out  WRITE_ADDR_WIDTH  to RAM
para_din  out  PARA_Y*PARA_KERNEL*DATA_WIDTH  to RAM
busy  out  1  state != IDLE or any pending flag set

Behaviour:
- Reset: all outputs 0 including ram_swap; state IDLE; pending flags, holding registers and round-robin pointer (rr, points to A) cleared. rst asserted mid-transaction aborts it immediately; enables drop on the same edge.
- Pending flags:
  - zero_req and layer_done each set a sticky flag. They are never lost while busy.
  - Re-pulsing a flag that is already set has no extra effect.
- FSM states: IDLE, ZERO, PARA, WORD, RELEASE.
- IDLE priority, highest first:
  1. Swap pending: toggle ram_swap, clear flag, stay IDLE.
  2. Zero pending: go to ZERO.
  3. Else round-robin between a_valid and b_valid.
  - When both pending flags are set, the swap applies first, so the clear targets the new half.
- Grant and capture:
  - Grant asserts x_ready in that IDLE cycle.
  - On valid&ready, addr/data/add are captured into holding registers.
  - rr moves to the other port.
  - Requester data need not be held after accept.
- ZERO: ena_zero_w=1 for exactly one cycle, then IDLE.
- PARA: ena_para_w=1 and ena_add_write=a_add; hold until write_ready=1 is sampled.
  - Expected RAM latency: 2*PARA_KERNEL cycles when adding, PARA_KERNEL when not.
  - Then RELEASE.
- WORD, add=0: ena_w=1 for one cycle, then IDLE; write_ready is ignored.
- WORD, add=1: hold ena_w until write_ready=1 is sampled, then RELEASE.
- RELEASE: all enables 0 for exactly one cycle so the RAM's internal counter and write_ready clear; then IDLE.
- Enable discipline: at most one of ena_zero_w/ena_w/ena_para_w is high in any cycle. Enables are registered and change only on state transitions.
- Accept rate: no requester is accepted outside IDLE, so back-to-back accepts are at least 2 cycles apart.
- write_ready high while in IDLE is ignored.
- Zero-cost swap: layer_done arriving while busy is applied only on return to IDLE, never mid-transaction.

Optional Feature:
Macro FM_WRITE_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, sticky until rst) and a cycle counter active in PARA and WORD(add=1).
  - If write_ready is not seen within TIMEOUT_CYCLES cycles: set timeout_err, go to RELEASE, drop the transaction.
- Undefined: no counter and no port; waiting is unbounded.

Decomposition:
- Shared package/header: the FSM state encoding (3-bit localparams), the DATA_WIDTH/PARA_Y/PARA_KERNEL/WRITE_ADDR_WIDTH defaults and the TIMEOUT_CYCLES default, alongside the existing CNN parameter header.
- One natural sub-module: fm_rr_arbiter_2 (2-way round-robin grant with pointer update on accept).

Test Plan:
- After rst, a_valid=1, a_add=1, a_addr=5; model write_ready after 6 cycles -> a_ready one cycle; ena_para_w high 6 cycles; ena_add_write=1; RELEASE one cycle with all enables 0; back to IDLE.
- b_valid=1, b_add=0, b_addr=3 -> ena_w high exactly 1 cycle with addr_write=3 and din=b_data; write_ready never needed; next accept possible 2 cycles after the first.
- a_valid and b_valid held continuously -> grants alternate A, B, A, B; no enable overlap; each b_ready follows an a_ready.
- layer_done and zero_req in the same cycle during an A transaction -> ram_swap toggles 0->1 on the first IDLE cycle; ena_zero_w pulses 1 cycle on the next; A completes unaffected.
- rst pulsed during PARA -> next cycle all enables 0, ram_swap=0, busy=0; a request after rst is accepted normally.
- With FM_WRITE_TIMEOUT_EN, write_ready held 0 for 64 cycles in PARA -> timeout_err=1; RELEASE; IDLE; timeout_err stays 1 until rst.
